// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic inter-stage pipeline register.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_SIZE = 32;
    localparam int unsigned PIPE_ADDR_SIZE = 10;
    localparam int unsigned PIPE_PC_SIZE   = PIPE_ADDR_SIZE + 2;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [PIPE_PC_SIZE-1:0]   pc;
        logic [PIPE_DATA_SIZE-1:0] inst;
    } stage_payload_t;

    // Entries held for a given state.
    function automatic logic [1:0] state_occupancy(input stage_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            BUSY:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with a synchronous active-low reset value.
module pipe_payload_reg #(
    parameter int unsigned       WIDTH   = 44,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: valid/ready handshake, 2-entry skid, flush, and
// a NOP bubble on the outputs whenever no valid entry is held.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned            DATA_SIZE = PIPE_DATA_SIZE,
    parameter int unsigned            ADDR_SIZE = PIPE_ADDR_SIZE,
    parameter logic [DATA_SIZE-1:0]   NOP_INST  = DATA_SIZE'(RV_NOP)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_SIZE+1:0]   pc_in,
    input  logic [DATA_SIZE-1:0]   inst_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_SIZE+1:0]   pc_out,
    output logic [DATA_SIZE-1:0]   inst_out,
    output logic [1:0]             occupancy
);

    localparam int unsigned PC_W = ADDR_SIZE + 2;
    localparam int unsigned PW   = PC_W + DATA_SIZE;
    localparam logic [PW-1:0] BUBBLE = {PC_W'(0), NOP_INST};

    stage_state_t state, state_nxt;

    logic          in_xfer, out_xfer;
    logic          main_load, skid_load;
    logic [PW-1:0] in_payload, main_d, skid_d, main_q, skid_q;

    assign in_payload = {pc_in, inst_in};
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;

    // Empty slots are reloaded with the bubble so outputs need no valid mask.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_d    = in_payload;
        skid_load = 1'b0;
        skid_d    = in_payload;
        if (flush) begin
            state_nxt = EMPTY;
            main_load = 1'b1;
            main_d    = BUBBLE;
            skid_load = 1'b1;
            skid_d    = BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_nxt = FULL;
                    end else if (out_xfer) begin
                        main_load = 1'b1;
                        main_d    = BUBBLE;
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        skid_load = 1'b1;
                        skid_d    = BUBBLE;
                        state_nxt = BUSY;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Handshake and status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
            occupancy <= state_occupancy(state_nxt);
        end
    end

    pipe_payload_reg #(
        .WIDTH   (PW),
        .RST_VAL (BUBBLE)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_payload_reg #(
        .WIDTH   (PW),
        .RST_VAL (BUBBLE)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (skid_d),
        .q     (skid_q)
    );

    assign pc_out   = main_q[PW-1 -: PC_W];
    assign inst_out = main_q[DATA_SIZE-1:0];

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic elastic pipeline register that replaces fixed inter-stage registers such as IF/ID and ID/EX in the pipelined core. It carries a PC and an instruction word between stages. It uses a valid/ready handshake and a 2-entry skid buffer, so a downstream stall never drops data and the stage keeps full throughput. It supports synchronous flush (branch/jump squash), and drives a NOP instruction whenever the stage holds no valid entry.

Parameters:
DATA_SIZE, 32, instruction word width in bits
ADDR_SIZE, 10, word-address width; the PC is ADDR_SIZE+2 bits (byte address)
NOP_INST, 32'h0000_0013, instruction driven on inst_out when out_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
flush  in  1  squash all held entries; inputs presented in the same cycle are discarded
in_valid  in  1  upstream presents pc_in/inst_in
in_ready  out  1  stage can accept; registered, equals !(state==FULL)
pc_in  in  ADDR_SIZE+2  upstream PC
inst_in  in  DATA_SIZE  upstream instruction
out_valid  out  1  pc_out/inst_out hold a valid entry
out_ready  in  1  downstream accepts
pc_out  out  ADDR_SIZE+2  PC of head entry; 0 when out_valid=0
inst_out  out  DATA_SIZE  instruction of head entry; NOP_INST when out_valid=0
occupancy  out  2  entries held (0..2), for performance counters and debug

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous, active-low, and has highest priority.
- Reset values: state=EMPTY, out_valid=0, in_ready=1, pc_out=0, inst_out=NOP_INST, occupancy=0. Skid contents are don't-care but are cleared to 0/NOP_INST.
- Transfer rules: an input transfer happens when in_valid&&in_ready. An output transfer happens when out_valid&&out_ready.
- Outputs come directly from the main register, with no combinational path from input to output. Latency is 1 cycle from input transfer to out_valid in the EMPTY state.
- in_ready is a registered signal with no combinational dependency on out_ready.
- FSM states:
  EMPTY: main and skid both invalid.
  BUSY: main valid, skid invalid.
  FULL: main and skid both valid.
- Transitions (absent flush):
  EMPTY: input transfer -> load main -> BUSY.
  BUSY, input only -> skid <= input -> FULL.
  BUSY, output only -> EMPTY.
  BUSY, input and output -> main <= input -> BUSY.
  BUSY, neither -> hold.
  FULL, output -> main <= skid -> BUSY. No input transfer is possible in FULL because in_ready=0.
  FULL, no output -> hold, all outputs stable.
- Ordering is strict FIFO: skid data always reaches the outputs before any later input.
- flush=1: next state is EMPTY, and occupancy, out_valid and in_ready are reset as at reset. An input transfer or output transfer in the flush cycle is ignored for state purposes. A downstream consumer that sampled out_valid&&out_ready in that cycle has consumed the entry.
- flush and rst_n low together: reset wins. The result is identical.
- Whenever out_valid=0: pc_out=0 and inst_out=NOP_INST, so a stage consuming without checking valid sees a harmless bubble.
- occupancy: 0/1/2 for EMPTY/BUSY/FULL. It never exceeds 2. Overflow is impossible by construction.
- Assertions (bench):
  - in_ready=0 implies occupancy=2.
  - While out_valid&&!out_ready with no flush, pc_out and inst_out are stable in the next cycle.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {EMPTY, BUSY, FULL} stage_state_t
  - localparam RV_NOP = 32'h0000_0013, which sets the NOP_INST default
  - typedef struct packed {pc, inst} stage_payload_t, width derived from the parameters via parametrised macros or localparams
- No sub-module required. A small payload register with load-enable (pipe_payload_reg) is a natural optional leaf, instantiated twice (main, skid).

Test Plan:
1. rst_n=0 for 2 cycles, then release -> out_valid=0, in_ready=1, pc_out=0, inst_out=32'h13, occupancy=0.
2. Stream PCs 0x000,0x004,0x008 with insts 0xA,0xB,0xC and out_ready=1 constantly -> each appears 1 cycle later, one per cycle, occupancy stays 1, in_ready stays 1.
3. BUSY with PC 0x010, drive out_ready=0 and input PC 0x014 -> occupancy=2, in_ready=0 next cycle, pc_out holds 0x010. Then out_ready=1 -> 0x010 then 0x014 in order, no loss, no duplication.
4. FULL (0x020, 0x024) and flush=1 with in_valid=1 for PC 0x028 -> next cycle out_valid=0, inst_out=NOP, occupancy=0, in_ready=1, and 0x028 never appears.
5. Random in_valid/out_ready (10k cycles) against a scoreboard queue -> exact in-order match, occupancy never >2, and stability assertion never fires.
6. Assert rst_n=0 while FULL, together with flush=1 -> reset values next cycle, and the first post-reset input emerges with 1-cycle latency.
